core_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the NPC RV32 datapath.
- Replaces the free-running single-cycle commit (PC and register file updated every clock) with an explicit fetch → execute → memory → commit schedule.
- Owns the instruction-memory and LSU request handshakes, latches the fetched instruction, and emits one-cycle commit strobes that gate the PC register enable and register-file write enable.
- Stops the core on ebreak, bus error or response timeout.

---
 rtl/core_seq_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl
// ---------------------------------------------------------------------------
// Multi-cycle sequencer for the NPC RV32 datapath. Instead of committing every
// clock, the core walks an explicit fetch -> execute -> memory -> commit
// schedule. This block owns the instruction-fetch and LSU request handshakes,
// latches the fetched instruction for the decoder, and produces one-cycle
// commit strobes that gate the PC register and register-file write enables.
// The core stops for good (until reset) on ebreak, bus error or a response
// that never arrives.
//
// Ports:
//   clk            core clock, all state changes on the rising edge
//   reset          asynchronous, active-low reset
//   pc             current PC from the PC register
//   ifu_req_*      instruction fetch request handshake and address
//   ifu_rsp_*      instruction fetch response (valid / error / data)
//   inst           latched instruction for decoder and datapath
//   inst_valid     inst is live (EXEC, MEM_REQ, MEM_WAIT)
//   dec_is_mem     decoder: current instruction is a load or store
//   dec_is_ebreak  decoder: current instruction is ebreak
//   lsu_req_*      data memory request handshake
//   lsu_rsp_*      data memory response (valid / error)
//   pc_wen         one-cycle PC register enable
//   rf_wen_gate    one-cycle gate ANDed with decoder rf_wen
//   instret        retired instruction count (wraps)
//   halted         ebreak reached
//   fault          bus error or response timeout
// ---------------------------------------------------------------------------
module core_seq_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_addr,
  input  logic            ifu_rsp_valid,
  input  logic            ifu_rsp_err,
  input  logic [XLEN-1:0] ifu_rsp_data,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  input  logic            dec_is_mem,
  input  logic            dec_is_ebreak,
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  input  logic            lsu_rsp_valid,
  input  logic            lsu_rsp_err,
  output logic            pc_wen,
  output logic            rf_wen_gate,
  output logic [31:0]     instret,
  output logic            halted,
  output logic            fault
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    EXEC,
    MEM_REQ,
    MEM_WAIT,
    HALT,
    FAULT
  } seqState_e;

  seqState_e       state_q;
  logic [TO_W-1:0] timeoutCnt_q;
  logic [TO_W-1:0] timeoutCnt_d;
  logic            timeoutHit;
  logic [31:0]     instret_q;
  logic [31:0]     instret_d;
  logic [XLEN-1:0] inst_q;
  logic            ifuReqValid_q;
  logic            lsuReqValid_q;
  logic            instValid_q;
  logic            halted_q;
  logic            fault_q;
  logic            commit;

  // The commit strobe is combinational so that a load retires in the very
  // cycle its response data is on the bus. It can only fire in EXEC or
  // MEM_WAIT, and both of those always leave for FETCH_REQ when it does, so
  // the strobe can never be high two cycles running.
  always_comb begin
    commit = 1'b0;
    case (state_q)
      EXEC:     commit = !dec_is_ebreak && !dec_is_mem;
      MEM_WAIT: commit = lsu_rsp_valid && !lsu_rsp_err;
      default:  commit = 1'b0;
    endcase
  end

  // The wait counter starts at zero on entry to a WAIT state, so hitting
  // TIMEOUT-1 means TIMEOUT full cycles have been spent waiting. A response
  // arriving in that last cycle still wins over the timeout.
  assign timeoutHit   = (timeoutCnt_q == TO_W'(TIMEOUT - 1));
  assign timeoutCnt_d = timeoutCnt_q + TO_W'(1);
  assign instret_d    = instret_q + 32'd1;

  // Sequencer state machine. Request valids, inst_valid, halted and fault are
  // registered alongside the state so they change exactly on state entry.
  // Responses are only looked at in the WAIT states, which is what makes
  // stale or early responses (REQ states, IDLE, after reset) harmless.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      timeoutCnt_q  <= '0;
      instret_q     <= '0;
      inst_q        <= '0;
      ifuReqValid_q <= 1'b0;
      lsuReqValid_q <= 1'b0;
      instValid_q   <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      if (commit) begin
        instret_q <= instret_d;
      end
      case (state_q)
        IDLE: begin
          state_q       <= FETCH_REQ;
          ifuReqValid_q <= 1'b1;
        end
        FETCH_REQ: begin
          if (ifu_req_ready) begin
            state_q       <= FETCH_WAIT;
            ifuReqValid_q <= 1'b0;
          end
        end
        FETCH_WAIT: begin
          if (ifu_rsp_valid) begin
            timeoutCnt_q <= '0;
            if (ifu_rsp_err) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q     <= EXEC;
              inst_q      <= ifu_rsp_data;
              instValid_q <= 1'b1;
            end
          end else if (timeoutHit) begin
            timeoutCnt_q <= '0;
            state_q      <= FAULT;
            fault_q      <= 1'b1;
          end else begin
            timeoutCnt_q <= timeoutCnt_d;
          end
        end
        EXEC: begin
          if (dec_is_ebreak) begin
            state_q     <= HALT;
            halted_q    <= 1'b1;
            instValid_q <= 1'b0;
          end else if (dec_is_mem) begin
            state_q       <= MEM_REQ;
            lsuReqValid_q <= 1'b1;
          end else begin
            state_q       <= FETCH_REQ;
            ifuReqValid_q <= 1'b1;
            instValid_q   <= 1'b0;
          end
        end
        MEM_REQ: begin
          if (lsu_req_ready) begin
            state_q       <= MEM_WAIT;
            lsuReqValid_q <= 1'b0;
          end
        end
        MEM_WAIT: begin
          if (lsu_rsp_valid) begin
            timeoutCnt_q <= '0;
            instValid_q  <= 1'b0;
            if (lsu_rsp_err) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q       <= FETCH_REQ;
              ifuReqValid_q <= 1'b1;
            end
          end else if (timeoutHit) begin
            timeoutCnt_q <= '0;
            instValid_q  <= 1'b0;
            state_q      <= FAULT;
            fault_q      <= 1'b1;
          end else begin
            timeoutCnt_q <= timeoutCnt_d;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        FAULT: begin
          state_q <= FAULT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The PC register does not change while a fetch is pending (pc_wen only
  // fires in EXEC / MEM_WAIT), so forwarding pc directly keeps the address
  // stable for the whole request. It reads as zero when no fetch is requested.
  assign ifu_addr      = ifuReqValid_q ? pc : '0;
  assign ifu_req_valid = ifuReqValid_q;
  assign lsu_req_valid = lsuReqValid_q;
  assign inst          = inst_q;
  assign inst_valid    = instValid_q;
  assign pc_wen        = commit;
  assign rf_wen_gate   = commit;
  assign instret       = instret_q;
  assign halted        = halted_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl
// ---------------------------------------------------------------------------
// Self-checking bench for core_seq_ctrl. The bench plays the role of the
// instruction memory, the LSU, the decoder and the PC register. Each task
// walks one phase of an instruction's life cycle by cycle and states what the
// sequencer should show in that cycle. Inputs the sequencer must ignore in a
// given phase are filled with random noise every cycle.
// ---------------------------------------------------------------------------
module tb_core_seq_ctrl;

  localparam int          XLEN     = 32;
  localparam int          TIMEOUT  = 20;
  localparam int          TO_W     = 5;
  localparam logic [31:0] START_PC = 32'h8000_0000;
  localparam logic [31:0] ADDI     = 32'h0010_0093;
  localparam logic [31:0] LW       = 32'h0000_2103;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     pcReg;
  logic            ifu_req_valid;
  logic            ifu_req_ready;
  logic [31:0]     ifu_addr;
  logic            ifu_rsp_valid;
  logic            ifu_rsp_err;
  logic [31:0]     ifu_rsp_data;
  logic [31:0]     inst;
  logic            inst_valid;
  logic            dec_is_mem;
  logic            dec_is_ebreak;
  logic            lsu_req_valid;
  logic            lsu_req_ready;
  logic            lsu_rsp_valid;
  logic            lsu_rsp_err;
  logic            pc_wen;
  logic            rf_wen_gate;
  logic [31:0]     instret;
  logic            halted;
  logic            fault;

  int              vectors = 0;
  int              miscompares = 0;
  logic [31:0]     expPc;
  logic [31:0]     expInstret;

  core_seq_ctrl #(
    .XLEN    (XLEN),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pcReg),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_err   (ifu_rsp_err),
    .ifu_rsp_data  (ifu_rsp_data),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .dec_is_mem    (dec_is_mem),
    .dec_is_ebreak (dec_is_ebreak),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_err   (lsu_rsp_err),
    .pc_wen        (pc_wen),
    .rf_wen_gate   (rf_wen_gate),
    .instret       (instret),
    .halted        (halted),
    .fault         (fault)
  );

  // Free-running core clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Stand-in for the datapath PC register: it advances by 4 whenever the
  // sequencer hands out a pc_wen strobe.
  always @(posedge clk or negedge reset) begin
    if (!reset) pcReg <= START_PC;
    else if (pc_wen) pcReg <= pcReg + 32'd4;
  end

  // Single comparison point: counts the vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Fill every input with random noise; phase tasks then override the inputs
  // that matter in that phase.
  task automatic applyStimulus();
    ifu_req_ready = 1'($urandom);
    ifu_rsp_valid = 1'($urandom);
    ifu_rsp_err   = 1'($urandom);
    ifu_rsp_data  = $urandom;
    dec_is_mem    = 1'($urandom);
    dec_is_ebreak = 1'($urandom);
    lsu_req_ready = 1'($urandom);
    lsu_rsp_valid = 1'($urandom);
    lsu_rsp_err   = 1'($urandom);
  endtask

  // Advance to one time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for a cycle in which the core is running normally.
  task automatic checkCycle(input string tag, input bit reqF, input bit reqL,
                            input bit wen, input bit iv);
    checkOutput({tag, ".ifu_req_valid"}, 32'(ifu_req_valid), 32'(reqF));
    if (reqF) checkOutput({tag, ".ifu_addr"}, ifu_addr, expPc);
    checkOutput({tag, ".lsu_req_valid"}, 32'(lsu_req_valid), 32'(reqL));
    checkOutput({tag, ".pc_wen"}, 32'(pc_wen), 32'(wen));
    checkOutput({tag, ".rf_wen_gate"}, 32'(rf_wen_gate), 32'(wen));
    checkOutput({tag, ".inst_valid"}, 32'(inst_valid), 32'(iv));
    checkOutput({tag, ".halted"}, 32'(halted), 32'd0);
    checkOutput({tag, ".fault"}, 32'(fault), 32'd0);
  endtask

  // Pull reset low between edges, confirm everything clears at once, then
  // release and spend the IDLE cycle with stale responses on both buses.
  // Leaves the core in its first FETCH_REQ cycle.
  task automatic resetDut();
    applyStimulus();
    reset = 1'b0;
    #1;
    checkOutput("rst.ifu_req_valid", 32'(ifu_req_valid), 32'd0);
    checkOutput("rst.ifu_addr", ifu_addr, 32'd0);
    checkOutput("rst.inst", inst, 32'd0);
    checkOutput("rst.inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst.lsu_req_valid", 32'(lsu_req_valid), 32'd0);
    checkOutput("rst.pc_wen", 32'(pc_wen), 32'd0);
    checkOutput("rst.rf_wen_gate", 32'(rf_wen_gate), 32'd0);
    checkOutput("rst.instret", instret, 32'd0);
    checkOutput("rst.halted", 32'(halted), 32'd0);
    checkOutput("rst.fault", 32'(fault), 32'd0);
    step();
    reset      = 1'b1;
    expPc      = START_PC;
    expInstret = 32'd0;
    applyStimulus();
    lsu_rsp_valid = 1'b1;
    lsu_rsp_err   = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_err   = 1'b0;
    #1;
    checkCycle("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  // FETCH_REQ for rdy stall cycles plus the handshake cycle, then FETCH_WAIT
  // with the response after rsp cycles (rsp >= TIMEOUT means it never comes).
  task automatic fetchPhase(input int rdy, input int rsp, input bit err,
                            input logic [31:0] word, output bit faulted);
    int n;
    for (int c = 0; c <= rdy; c++) begin
      applyStimulus();
      ifu_req_ready = (c == rdy);
      #1;
      checkCycle("fetchReq", 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    n = (rsp >= TIMEOUT) ? TIMEOUT : rsp + 1;
    for (int c = 0; c < n; c++) begin
      applyStimulus();
      ifu_rsp_valid = (rsp < TIMEOUT) && (c == rsp);
      ifu_rsp_err   = err && ifu_rsp_valid;
      ifu_rsp_data  = word;
      #1;
      checkCycle("fetchWait", 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    faulted = err || (rsp >= TIMEOUT);
  endtask

  // EXEC: the decoder flags are presented; plain instructions commit here.
  task automatic execPhase(input bit isMem, input bit isBrk, input logic [31:0] word);
    bit wen;
    wen = !isMem && !isBrk;
    applyStimulus();
    dec_is_mem    = isMem;
    dec_is_ebreak = isBrk;
    #1;
    checkCycle("exec", 1'b0, 1'b0, wen, 1'b1);
    checkOutput("exec.inst", inst, word);
    checkOutput("exec.instret", instret, expInstret);
    step();
    if (wen) begin
      expInstret = expInstret + 32'd1;
      expPc      = expPc + 32'd4;
    end
  endtask

  // MEM_REQ with rdy stall cycles, then MEM_WAIT with the response after rsp
  // cycles; a good response commits in the same cycle it is seen.
  task automatic memPhase(input int rdy, input int rsp, input bit err,
                          output bit faulted);
    int n;
    bit wen;
    for (int c = 0; c <= rdy; c++) begin
      applyStimulus();
      dec_is_mem    = 1'b1;
      dec_is_ebreak = 1'b0;
      lsu_req_ready = (c == rdy);
      #1;
      checkCycle("memReq", 1'b0, 1'b1, 1'b0, 1'b1);
      step();
    end
    n = (rsp >= TIMEOUT) ? TIMEOUT : rsp + 1;
    for (int c = 0; c < n; c++) begin
      applyStimulus();
      lsu_rsp_valid = (rsp < TIMEOUT) && (c == rsp);
      lsu_rsp_err   = err && lsu_rsp_valid;
      wen           = lsu_rsp_valid && !err;
      #1;
      checkCycle("memWait", 1'b0, 1'b0, wen, 1'b1);
      step();
      if (wen) begin
        expInstret = expInstret + 32'd1;
        expPc      = expPc + 32'd4;
      end
    end
    faulted = err || (rsp >= TIMEOUT);
  endtask

  // One complete error-free instruction starting from FETCH_REQ.
  task automatic runInstr(input logic [31:0] word, input bit isMem, input int fRdy,
                          input int fRsp, input int mRdy, input int mRsp);
    bit faulted;
    fetchPhase(fRdy, fRsp, 1'b0, word, faulted);
    execPhase(isMem, 1'b0, word);
    if (isMem) memPhase(mRdy, mRsp, 1'b0, faulted);
  endtask

  // After HALT or FAULT the bus must stay quiet and the flags must hold.
  task automatic terminalPhase(input bit expHalt, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      applyStimulus();
      #1;
      checkOutput("term.ifu_req_valid", 32'(ifu_req_valid), 32'd0);
      checkOutput("term.lsu_req_valid", 32'(lsu_req_valid), 32'd0);
      checkOutput("term.pc_wen", 32'(pc_wen), 32'd0);
      checkOutput("term.halted", 32'(halted), 32'(expHalt));
      checkOutput("term.fault", 32'(fault), 32'(!expHalt));
      checkOutput("term.instret", instret, expInstret);
      step();
    end
  endtask

  initial begin
    bit faulted;
    applyStimulus();
    #2;

    // Zero-wait addi: request in cycle 1, commit in cycle 3, next fetch at pc+4.
    resetDut();
    runInstr(ADDI, 1'b0, 0, 0, 0, 0);
    checkOutput("addi.instret", instret, 32'd1);
    checkOutput("addi.pcReg", pcReg, START_PC + 32'd4);

    // Fetch stalled five cycles on ready, then a load answered 3 cycles late.
    runInstr(ADDI, 1'b0, 5, 0, 0, 0);
    runInstr(LW, 1'b1, 0, 1, 0, 3);
    checkOutput("load.instret", instret, 32'd3);

    // Responses landing in the very last cycle before the timeout still count.
    runInstr(ADDI, 1'b0, 2, TIMEOUT - 1, 0, 0);
    runInstr(LW, 1'b1, 0, 0, 4, TIMEOUT - 1);
    checkOutput("edge.instret", instret, 32'd5);

    // Random mix of ALU and memory instructions with random handshake delays.
    for (int i = 0; i < 40; i++) begin
      runInstr($urandom, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3));
    end
    checkOutput("rand.instret", instret, expInstret);

    // Four addi then ebreak: no commit for ebreak, halted, bus idle for 50 cycles.
    resetDut();
    for (int i = 0; i < 4; i++) runInstr(ADDI, 1'b0, 0, 0, 0, 0);
    fetchPhase(0, 0, 1'b0, EBREAK, faulted);
    execPhase(1'b0, 1'b1, EBREAK);
    checkOutput("ebreak.instret", instret, 32'd4);
    terminalPhase(1'b1, 50);

    // Bus error on the second fetch.
    resetDut();
    runInstr(ADDI, 1'b0, 0, 0, 0, 0);
    fetchPhase(1, 2, 1'b1, ADDI, faulted);
    terminalPhase(1'b0, 20);

    // Fetch response never arrives.
    resetDut();
    fetchPhase(0, TIMEOUT, 1'b0, ADDI, faulted);
    terminalPhase(1'b0, 20);

    // Load with a data bus error, then a load whose response never arrives.
    resetDut();
    runInstr(ADDI, 1'b0, 0, 0, 0, 0);
    fetchPhase(0, 0, 1'b0, LW, faulted);
    execPhase(1'b1, 1'b0, LW);
    memPhase(1, 2, 1'b1, faulted);
    terminalPhase(1'b0, 10);
    resetDut();
    fetchPhase(0, 0, 1'b0, LW, faulted);
    execPhase(1'b1, 1'b0, LW);
    memPhase(0, TIMEOUT, 1'b0, faulted);
    terminalPhase(1'b0, 10);

    // Reset in the middle of MEM_WAIT; the late response must not commit and
    // fetching restarts from the reset PC.
    resetDut();
    runInstr(ADDI, 1'b0, 0, 0, 0, 0);
    fetchPhase(0, 0, 1'b0, LW, faulted);
    execPhase(1'b1, 1'b0, LW);
    for (int c = 0; c < 1; c++) begin
      applyStimulus();
      lsu_req_ready = 1'b1;
      #1;
      checkCycle("preRst.memReq", 1'b0, 1'b1, 1'b0, 1'b1);
      step();
    end
    for (int c = 0; c < 2; c++) begin
      applyStimulus();
      lsu_rsp_valid = 1'b0;
      #1;
      checkCycle("preRst.memWait", 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    resetDut();
    runInstr(ADDI, 1'b0, 0, 0, 0, 0);
    checkOutput("restart.instret", instret, 32'd1);
    checkOutput("restart.pcReg", pcReg, START_PC + 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
